cnt_job_scheduler: RTL and testbench

//  Shares one fsm_counter instance among N_REQ requesters. Round-robin

---
 rtl/cnt_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/cnt_job_scheduler.sv | 129 ++++++++++++
 tb/tb_cnt_job_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared constants for the counter job scheduler: FSM state encoding and the
// default count width used by the scheduler, fsm_counter and their benches.
package cnt_sched_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        DRAIN      = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       idx
);

    logic hit;

    always_comb begin
        idx = '0;
        hit = 1'b0;
        // Scan from the farthest offset down so the closest one to ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) begin
                idx = 3'((int'(ptr) + i) % N_REQ);
                hit = 1'b1;
            end
        end
        gnt = hit ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/cnt_job_scheduler.sv
// Shares one fsm_counter among N_REQ requesters: round-robin grant, run pulse,
// status tracking and a per-requester done (or start-timeout error) pulse.
module cnt_job_scheduler
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int START_TO = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*CNT_W-1:0] i_req_num,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_err,
    output logic                   o_busy,
    output logic [2:0]             o_owner,
    output logic                   o_cnt_run,
    output logic [CNT_W-1:0]       o_cnt_num,
    input  logic                   i_cnt_idle,
    input  logic                   i_cnt_running,
    input  logic                   i_cnt_done
);

    localparam int TMR_W = $clog2(START_TO + 1);

    sched_state_t     state, state_nxt;
    logic [2:0]       rr_ptr;
    logic [TMR_W-1:0] timer;
    logic [N_REQ-1:0] arb_gnt;
    logic [2:0]       arb_idx;
    logic [CNT_W-1:0] arb_num;
    logic [N_REQ-1:0] owner_oh;
    logic             grant_set;
    logic             done_set;
    logic             err_set;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (i_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_num  = i_req_num[arb_idx*CNT_W +: CNT_W];
    assign owner_oh = N_REQ'(1) << o_owner;
    assign o_busy   = (state != IDLE);

    function automatic logic [2:0] ptr_next(input logic [2:0] k);
        return (int'(k) == N_REQ - 1) ? 3'd0 : k + 3'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        grant_set = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req && i_cnt_idle) begin
                    state_nxt = ISSUE;
                    grant_set = 1'b1;
                end
            end
            ISSUE: begin
                // A zero-length job never touches the counter.
                if (o_cnt_num == '0) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (i_cnt_done) begin
                    state_nxt = DRAIN;
                    done_set  = 1'b1;
                end else if (i_cnt_running) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == TMR_W'(START_TO)) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (i_cnt_done) begin
                    state_nxt = DRAIN;
                    done_set  = 1'b1;
                end
            end
            DRAIN: begin
                if (i_cnt_idle) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            timer     <= '0;
            o_owner   <= '0;
            o_cnt_num <= '0;
            o_grant   <= '0;
            o_done    <= '0;
            o_err     <= 1'b0;
            o_cnt_run <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_grant   <= grant_set ? arb_gnt : '0;
            o_cnt_run <= grant_set && (arb_num != '0);
            o_done    <= done_set ? owner_oh : '0;
            o_err     <= err_set;
            if (grant_set) begin
                o_owner   <= arb_idx;
                o_cnt_num <= arb_num;
            end
            if (state == ISSUE) rr_ptr <= ptr_next(o_owner);
            // Timer holds the number of cycles spent in WAIT_START, saturating.
            if (state == ISSUE)
                timer <= TMR_W'(1);
            else if (state == WAIT_START && timer != TMR_W'(START_TO))
                timer <= timer + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_cnt_job_scheduler.sv
// Scoreboard bench for cnt_job_scheduler with a small behavioural fsm_counter
// acting as the shared resource (optionally stubbed to never start).
`timescale 1ns/1ps
module tb_cnt_job_scheduler;

    localparam int N_REQ    = 4;
    localparam int CNT_W    = 8;
    localparam int START_TO = 4;
    localparam int K_GRANT  = 0;
    localparam int K_DONE   = 1;
    localparam int K_ERR    = 2;

    typedef struct {
        int kind;
        int idx;
        int num;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [N_REQ-1:0]       i_req = '0;
    logic [N_REQ*CNT_W-1:0] i_req_num = '0;
    logic [N_REQ-1:0]       o_grant;
    logic [N_REQ-1:0]       o_done;
    logic                   o_err;
    logic                   o_busy;
    logic [2:0]             o_owner;
    logic                   o_cnt_run;
    logic [CNT_W-1:0]       o_cnt_num;
    logic                   cnt_idle;
    logic                   cnt_running;
    logic                   cnt_done;

    logic [1:0]             c_st;
    logic [CNT_W-1:0]       c_rem;
    logic                   stub = 1'b0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cnt_job_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W), .START_TO(START_TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_req_num     (i_req_num),
        .o_grant       (o_grant),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .o_owner       (o_owner),
        .o_cnt_run     (o_cnt_run),
        .o_cnt_num     (o_cnt_num),
        .i_cnt_idle    (cnt_idle),
        .i_cnt_running (cnt_running),
        .i_cnt_done    (cnt_done)
    );

    // Counter model: idle -> running for num cycles -> done for one cycle -> idle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_st  <= 2'd0;
            c_rem <= '0;
        end else begin
            case (c_st)
                2'd0: if (o_cnt_run && !stub) begin
                    if (o_cnt_num == '0) c_st <= 2'd2;
                    else begin
                        c_st  <= 2'd1;
                        c_rem <= o_cnt_num;
                    end
                end
                2'd1: if (c_rem <= 1) c_st <= 2'd2;
                      else c_rem <= c_rem - 1'b1;
                default: c_st <= 2'd0;
            endcase
        end
    end

    assign cnt_idle    = stub ? 1'b1 : (c_st == 2'd0);
    assign cnt_running = !stub && (c_st == 2'd1);
    assign cnt_done    = !stub && (c_st == 2'd2);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int idx, input int num);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.num  = num;
        sb.push_back(e);
    endtask

    task automatic set_num(input int k, input int v);
        i_req_num[k*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Advances at least one negedge; n = negedges until o_grant seen.
    task automatic wait_grant(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (o_grant != '0) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant within 100 cycles (t=%0t)", $time);
        end
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("idle_reached", int'(seen), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, int'(o_grant), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_err"}, int'(o_err), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_owner"}, int'(o_owner), 0);
        chk({tag, "_cnt_num"}, int'(o_cnt_num), 0);
        chk({tag, "_cnt_run"}, int'(o_cnt_run), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a grant, done or error.
    always @(negedge clk) begin
        exp_t e;
        if (o_grant != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %b, expected no grant", o_grant);
            end else begin
                e = sb.pop_front();
                chk("grant_kind", K_GRANT, e.kind);
                chk("grant_vec", int'(o_grant), 1 << e.idx);
                chk("grant_owner", int'(o_owner), e.idx);
                chk("grant_cnt_num", int'(o_cnt_num), e.num);
                chk("grant_cnt_run", int'(o_cnt_run), int'(e.num != 0));
            end
        end
        if (o_done != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got %b, expected no done", o_done);
            end else begin
                e = sb.pop_front();
                chk("done_kind", K_DONE, e.kind);
                chk("done_vec", int'(o_done), 1 << e.idx);
                chk("done_no_err", int'(o_err), 0);
            end
        end else if (o_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: got 1, expected no error");
            end else begin
                e = sb.pop_front();
                chk("err_kind", K_ERR, e.kind);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Single job on requester 0, count 5; later edit of its count is ignored.
        reset = 1'b1;
        @(negedge clk);
        set_num(0, 5);
        i_req = 4'b0001;
        push(K_GRANT, 0, 5);
        push(K_DONE, 0, 0);
        wait_grant(n);
        chk("grant_latency", n, 1);
        i_req = i_req & ~o_grant;
        set_num(0, 9);
        repeat (3) @(negedge clk);
        chk("num_held_busy", int'(o_busy), 1);
        chk("num_held", int'(o_cnt_num), 5);
        wait_idle();
        chk("single_busy_low", int'(o_busy), 0);

        // All four requesting from reset release: order 0,1,2,3, then 0 and 2.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N_REQ; k++) set_num(k, k + 1);
        i_req = 4'b1111;
        for (int k = 0; k < N_REQ; k++) begin
            push(K_GRANT, k, k + 1);
            push(K_DONE, k, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            wait_grant(n);
            i_req = i_req & ~o_grant;
        end
        wait_idle();
        i_req = 4'b0101;
        push(K_GRANT, 0, 1);
        push(K_DONE, 0, 0);
        push(K_GRANT, 2, 3);
        push(K_DONE, 2, 0);
        for (int k = 0; k < 2; k++) begin
            wait_grant(n);
            i_req = i_req & ~o_grant;
        end
        wait_idle();

        // Zero-length job on requester 1: done on the very next cycle, no run.
        set_num(1, 0);
        i_req = 4'b0010;
        push(K_GRANT, 1, 0);
        push(K_DONE, 1, 0);
        wait_grant(n);
        i_req = i_req & ~o_grant;
        @(negedge clk);
        chk("zero_done_next", int'(o_done), 4'b0010);
        chk("zero_counter_idle", int'(c_st), 0);
        wait_idle();

        // Counter stubbed to never start: start-timeout error, no done.
        stub = 1'b1;
        set_num(3, 7);
        i_req = 4'b1000;
        push(K_GRANT, 3, 7);
        push(K_ERR, 0, 0);
        wait_grant(n);
        i_req = i_req & ~o_grant;
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (o_err) begin
                n = i;
                break;
            end
        end
        chk("err_delay", n, START_TO + 1);
        wait_idle();
        chk("err_busy_low", int'(o_busy), 0);
        stub = 1'b0;

        // Asynchronous reset in the middle of a long job, then a fresh job.
        set_num(2, 20);
        i_req = 4'b0100;
        push(K_GRANT, 2, 20);
        wait_grant(n);
        i_req = i_req & ~o_grant;
        repeat (5) @(negedge clk);
        chk("mid_job_busy", int'(o_busy), 1);
        chk("mid_job_running", int'(cnt_running), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        set_num(2, 3);
        i_req = 4'b0100;
        push(K_GRANT, 2, 3);
        push(K_DONE, 2, 0);
        wait_grant(n);
        i_req = i_req & ~o_grant;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
